// File: rtl/ex_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ex_mem_pipe_pkg
//  Brief   : Constants, stall indices and slot-action decode shared by the
//            pipeline stage registers.
//  Rev     : 1.0  initial release
// ============================================================================
package ex_mem_pipe_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    localparam int STALL_W = 6;
    localparam int EX_IDX  = 3;
    localparam int MEM_IDX = 4;

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_ADVANCE = 3'd3,
        ACT_HOLD    = 3'd4
    } pipe_act_e;

    // sx=0 with sm=1 cannot come from the control block; it falls into advance.
    function automatic pipe_act_e pipe_action(
        input logic rst_v,
        input logic flush_v,
        input logic sx,
        input logic sm
    );
        if (rst_v == RstEnable) begin
            return ACT_RESET;
        end else if (flush_v) begin
            return ACT_FLUSH;
        end else if (!sx) begin
            return ACT_ADVANCE;
        end else if (!sm) begin
            return ACT_BUBBLE;
        end else begin
            return ACT_HOLD;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : ex_mem_pipe_sat_counter
//  Brief   : Saturating up-counter with synchronous clear, used for stall and
//            bubble statistics in the stage registers.
//  Rev     : 1.0  initial release
// ============================================================================
module ex_mem_pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Stops at all-ones so a long stall storm never wraps back to a small value.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : ex_mem_pipe
//  Brief   : EX/MEM pipeline register with stall, flush, bubble insertion and
//            madd/msub accumulator feedback to the execute stage.
//  Rev     : 1.0  initial release
// ============================================================================
module ex_mem_pipe #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 2,
    parameter int STALL_W = ex_mem_pipe_pkg::STALL_W,
    parameter int EX_IDX  = ex_mem_pipe_pkg::EX_IDX,
    parameter int MEM_IDX = ex_mem_pipe_pkg::MEM_IDX,
    parameter int BUB_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [RADDR_W-1:0]    ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [CNT_W-1:0]      cnt_i,
    input  logic [2*DATA_W-1:0]   hilo_i,
    output logic [RADDR_W-1:0]    mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_valid,
    output logic [CNT_W-1:0]      cnt_o,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [BUB_W-1:0]      bubble_cnt
);

    import ex_mem_pipe_pkg::*;

    localparam int HILO_W = 2 * DATA_W;

    localparam logic [RADDR_W-1:0] NOP_ADDR  = RADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0]  ZERO_DATA = DATA_W'(ZeroWord);

    pipe_act_e           w_act;
    logic                unused_stall;

    logic [RADDR_W-1:0]  wd_q,    wd_d;
    logic                wreg_q,  wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q,    hi_d;
    logic [DATA_W-1:0]   lo_q,    lo_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [HILO_W-1:0]   hilo_q,  hilo_d;

    assign w_act        = pipe_action(rst, flush, stall[EX_IDX], stall[MEM_IDX]);
    // Only the EX and MEM bits steer this register; the rest belong to other stages.
    assign unused_stall = ^stall;

    always_comb begin
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        hilo_d  = hilo_q;

        case (w_act)
            ACT_RESET, ACT_FLUSH: begin
                wd_d    = NOP_ADDR;
                wreg_d  = WriteDisable;
                wdata_d = ZERO_DATA;
                whilo_d = WriteDisable;
                hi_d    = ZERO_DATA;
                lo_d    = ZERO_DATA;
                valid_d = 1'b0;
                cnt_d   = '0;
                hilo_d  = '0;
            end
            // Bubble into MEM while the madd/msub partial result loops back to EX.
            ACT_BUBBLE: begin
                wd_d    = NOP_ADDR;
                wreg_d  = WriteDisable;
                wdata_d = ZERO_DATA;
                whilo_d = WriteDisable;
                hi_d    = ZERO_DATA;
                lo_d    = ZERO_DATA;
                valid_d = 1'b0;
                cnt_d   = cnt_i;
                hilo_d  = hilo_i;
            end
            ACT_ADVANCE: begin
                wd_d    = ex_wd;
                wreg_d  = ex_wreg;
                wdata_d = ex_wdata;
                whilo_d = ex_whilo;
                hi_d    = ex_hi;
                lo_d    = ex_lo;
                valid_d = 1'b1;
                cnt_d   = '0;
                hilo_d  = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wd_q    <= NOP_ADDR;
            wreg_q  <= WriteDisable;
            wdata_q <= ZERO_DATA;
            whilo_q <= WriteDisable;
            hi_q    <= ZERO_DATA;
            lo_q    <= ZERO_DATA;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            hilo_q  <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
        end
    end

    ex_mem_pipe_sat_counter #(
        .WIDTH (BUB_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (w_act == ACT_BUBBLE),
        .count_o (bubble_cnt)
    );

    assign mem_wd    = wd_q;
    assign mem_wreg  = wreg_q;
    assign mem_wdata = wdata_q;
    assign mem_whilo = whilo_q;
    assign mem_hi    = hi_q;
    assign mem_lo    = lo_q;
    assign mem_valid = valid_q;
    assign cnt_o     = cnt_q;
    assign hilo_o    = hilo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ex_mem_pipe
//  Brief   : Directed scoreboard bench for ex_mem_pipe (default widths) plus a
//            BUB_W=2 instance for bubble-counter saturation.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [1:0]  cnt_i;
    logic [63:0] hilo_i;

    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_valid;
    logic [1:0]  cnt_o;
    logic [63:0] hilo_o;
    logic [15:0] bubble_cnt;

    logic [4:0]  s_wd;
    logic        s_wreg;
    logic [31:0] s_wdata;
    logic        s_whilo;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic        s_valid;
    logic [1:0]  s_cnt;
    logic [63:0] s_hilo;
    logic [1:0]  s_bub;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        valid;
        logic [1:0]  cnt;
        logic [63:0] hilo;
        logic [15:0] bub;
        logic [1:0]  bub2;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_mem_pipe u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_wdata   (ex_wdata),
        .ex_whilo   (ex_whilo),
        .ex_hi      (ex_hi),
        .ex_lo      (ex_lo),
        .cnt_i      (cnt_i),
        .hilo_i     (hilo_i),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .mem_valid  (mem_valid),
        .cnt_o      (cnt_o),
        .hilo_o     (hilo_o),
        .bubble_cnt (bubble_cnt)
    );

    ex_mem_pipe #(
        .BUB_W (2)
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_wd      (ex_wd),
        .ex_wreg    (ex_wreg),
        .ex_wdata   (ex_wdata),
        .ex_whilo   (ex_whilo),
        .ex_hi      (ex_hi),
        .ex_lo      (ex_lo),
        .cnt_i      (cnt_i),
        .hilo_i     (hilo_i),
        .mem_wd     (s_wd),
        .mem_wreg   (s_wreg),
        .mem_wdata  (s_wdata),
        .mem_whilo  (s_whilo),
        .mem_hi     (s_hi),
        .mem_lo     (s_lo),
        .mem_valid  (s_valid),
        .cnt_o      (s_cnt),
        .hilo_o     (s_hilo),
        .bubble_cnt (s_bub)
    );

    // The control block never drives EX running with MEM stalled.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("illegal stall vector %b", stall);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
            end
    endtask

    // Reference behaviour applied to the inputs present before the edge.
    task automatic model_update();
        logic sx;
        logic sm;
        sx = stall[3];
        sm = stall[4];
        if (rst) begin
            m = '0;
        end else if (flush) begin
            m.wd = '0; m.wreg = 1'b0; m.wdata = '0; m.whilo = 1'b0;
            m.hi = '0; m.lo = '0; m.valid = 1'b0; m.cnt = '0; m.hilo = '0;
        end else if (sx && !sm) begin
            m.wd = '0; m.wreg = 1'b0; m.wdata = '0; m.whilo = 1'b0;
            m.hi = '0; m.lo = '0; m.valid = 1'b0;
            m.cnt = cnt_i; m.hilo = hilo_i;
            if (m.bub != 16'hFFFF) m.bub = m.bub + 16'd1;
            if (m.bub2 != 2'b11)   m.bub2 = m.bub2 + 2'd1;
        end else if (!sx) begin
            m.wd = ex_wd; m.wreg = ex_wreg; m.wdata = ex_wdata; m.whilo = ex_whilo;
            m.hi = ex_hi; m.lo = ex_lo; m.valid = 1'b1; m.cnt = '0; m.hilo = '0;
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_update();
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed none required entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".wd"},    64'(mem_wd),     64'(e.wd));
            chk({tag, ".wreg"},  64'(mem_wreg),   64'(e.wreg));
            chk({tag, ".wdata"}, 64'(mem_wdata),  64'(e.wdata));
            chk({tag, ".whilo"}, 64'(mem_whilo),  64'(e.whilo));
            chk({tag, ".hi"},    64'(mem_hi),     64'(e.hi));
            chk({tag, ".lo"},    64'(mem_lo),     64'(e.lo));
            chk({tag, ".valid"}, 64'(mem_valid),  64'(e.valid));
            chk({tag, ".cnt"},   64'(cnt_o),      64'(e.cnt));
            chk({tag, ".hilo"},  hilo_o,          e.hilo);
            chk({tag, ".bub"},   64'(bubble_cnt), 64'(e.bub));
            chk({tag, ".bub2"},  64'(s_bub),      64'(e.bub2));
        end
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_whilo = whilo; ex_hi = hi; ex_lo = lo;
    endtask

    initial begin
        m = '0;
        // Reset with every input non-zero, flush and stall active too.
        rst = 1'b1; flush = 1'b1; stall = 6'b111111;
        set_ex(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        cnt_i = 2'b11; hilo_i = 64'hFFFF_FFFF_FFFF_FFFF;
        step("reset0");
        step("reset1");

        // Pass-through.
        rst = 1'b0; flush = 1'b0; stall = 6'b000000;
        set_ex(5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1111_2222, 32'h3333_4444);
        cnt_i = 2'b10; hilo_i = 64'h5555_6666_7777_8888;
        step("pass");

        // madd stall: bubble in MEM, accumulator fed back.
        stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h0000_0001_0000_0002;
        step("madd_stall");

        stall = 6'b000000;
        set_ex(5'd7, 1'b1, 32'hCAFE_F00D, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        step("madd_done");

        // Full hold while EX inputs keep changing.
        set_ex(5'd12, 1'b1, 32'h0BAD_CAFE, 1'b1, 32'h0000_00AA, 32'h0000_00BB);
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(i + 20), 1'b0, 32'(i * 32'h0101_0101), 1'b0, 32'(i), 32'(~i));
            cnt_i = 2'(i); hilo_i = 64'(i) << 8;
            step($sformatf("hold%0d", i));
        end

        // Flush during a madd stall sequence.
        stall = 6'b001111; cnt_i = 2'b01; hilo_i = 64'h0000_0003_0000_0004;
        step("flush_pre");
        flush = 1'b1;
        step("flush");
        flush = 1'b0;

        // Bits other than EX/MEM are don't-care.
        stall = 6'b100111;
        set_ex(5'd9, 1'b0, 32'h1357_9BDF, 1'b1, 32'h2468_ACE0, 32'hFEDC_BA98);
        step("ignore_bits");

        // Saturation on the BUB_W=2 instance.
        rst = 1'b1;
        step("sat_reset");
        rst = 1'b0; stall = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            cnt_i = 2'(i); hilo_i = 64'(i + 100);
            step($sformatf("sat%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX/MEM pipeline register with stall, flush and bubble insertion.
- Carries GPR write-back, HI/LO write and multi-cycle (madd/msub) accumulator state from the execute stage to the memory stage.
- Follows the 6-bit stall-vector convention of the pipeline control block.
- Adds a valid flag and a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, width of GPR data, HI and LO
RADDR_W, 5, register-file address width
CNT_W, 2, multi-cycle step counter width
STALL_W, 6, stall vector width
EX_IDX, 3, stall bit index for the EX stage
MEM_IDX, 4, stall bit index for the MEM stage
BUB_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  STALL_W  pipeline stall vector from the control block
flush  in  1  exception/pipeline flush, synchronous
ex_wd  in  RADDR_W  destination GPR address
ex_wreg  in  1  GPR write enable
ex_wdata  in  DATA_W  GPR write data
ex_whilo  in  1  HI/LO write enable
ex_hi  in  DATA_W  HI write data
ex_lo  in  DATA_W  LO write data
cnt_i  in  CNT_W  multi-cycle step from EX
hilo_i  in  2*DATA_W  partial {hi,lo} from EX
mem_wd  out  RADDR_W  registered ex_wd
mem_wreg  out  1  registered ex_wreg
mem_wdata  out  DATA_W  registered ex_wdata
mem_whilo  out  1  registered ex_whilo
mem_hi  out  DATA_W  registered ex_hi
mem_lo  out  DATA_W  registered ex_lo
mem_valid  out  1  1 = slot holds a real instruction, 0 = bubble
cnt_o  out  CNT_W  step fed back to EX
hilo_o  out  2*DATA_W  partial product fed back to EX
bubble_cnt  out  BUB_W  count of bubbles inserted since reset

Behaviour:
- All state updates on the rising edge of clk. Latency is 1 cycle, EX inputs to MEM outputs.
- Let sx = stall[EX_IDX] and sm = stall[MEM_IDX]. Conditions below are evaluated in priority order.
- 1. rst=1:
  - mem_wd=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0.
  - mem_valid=0, cnt_o=0, hilo_o=0, bubble_cnt=0.
  - Every output is reset, including cnt_o and hilo_o.
- 2. flush=1:
  - Same values as reset, except bubble_cnt holds.
  - In-flight madd/msub state is discarded.
- 3. sx=1, sm=0 (EX stalled, MEM proceeds):
  - Insert a bubble: all mem_* write enables and data = 0, mem_valid=0.
  - cnt_o<=cnt_i and hilo_o<=hilo_i, so the multi-cycle accumulation survives the stall.
  - bubble_cnt increments, saturating at all-ones with no wrap.
- 4. sx=0 (normal advance):
  - All mem_* <= the corresponding ex_* inputs, mem_valid=1.
  - cnt_o=0 and hilo_o=0, because the multi-cycle op has completed or is not in use.
- 5. sx=1, sm=1 (both stalled): every output holds its value. bubble_cnt holds.
- sx=0 with sm=1 is illegal; the control block never produces it. Treat it as case 4. Verification flags it with an assertion.
- flush asserted during a madd stall sequence: the flush wins, cnt_o=0 on the next cycle.
- rst asserted with flush or stall: rst wins.
- Stall bits other than EX_IDX and MEM_IDX are ignored.
- No combinational path from any input to any output.

Decomposition:
- Shared package/defines: RstEnable, WriteDisable, ZeroWord, NOPRegAddr, and the stall index constants EX_IDX/MEM_IDX (shared with the other stage registers).
- One sub-module is natural: sat_counter (BUB_W-bit saturating incrementer with sync clear). It is reusable by the other stage registers for stall statistics.
- Everything else is flat.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs non-zero -> every output 0, including cnt_o, hilo_o and bubble_cnt.
- Pass-through: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF -> next cycle mem_wd=3, mem_wdata=32'hDEADBEEF, mem_valid=1, cnt_o=0.
- madd stall: stall=6'b001111, cnt_i=2'b01, hilo_i=64'h0000_0001_0000_0002 -> mem_wreg=0, mem_valid=0, cnt_o=1, hilo_o=64'h0000_0001_0000_0002, bubble_cnt=1.
  - Then stall=0 -> cnt_o=0 and mem_* take the EX values.
- Full hold: load a value, then apply stall=6'b011111 for 3 cycles while changing ex_* -> outputs unchanged, bubble_cnt unchanged.
- Flush: during the madd stall (cnt_o=1), assert flush=1 -> next cycle cnt_o=0, hilo_o=0, mem_valid=0, bubble_cnt keeps its value.
- Saturation: BUB_W=2, apply 5 consecutive bubble cycles -> bubble_cnt sequence 1,2,3,3,3.
